// File: rtl/wb_arb2_pkg.sv
// Shared types for the two-master Wishbone arbiter.
package wb_arb2_pkg;

  // Arbiter state: waiting for a request, owning the bus, or one-cycle holdoff.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_t;

  // One-hot grant vector for a 1-bit owner id (bit0 = m0).
  function automatic logic [1:0] owner_onehot(input logic own);
    return own ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_arb2.sv
// Two-master Wishbone arbiter: round-robin grant locked for the whole cycle,
// one-cycle holdoff after each cycle, and a watchdog that aborts stalled cycles.
//
// Handshake: a master requests by raising one lane of mX_cyc and holds it (with
// addr/wdata/we stable) until it sees the matching mX_ack lane high for one
// cycle; the transfer completes in that cycle. Dropping cyc before ack abandons
// the cycle. Slaves answer wb_cyc with wb_ack in the same lane.
module wb_arb2
  import wb_arb2_pkg::*;
#(
  parameter int WB_N    = 1,
  parameter int TIMEOUT = 255,
  parameter int DL      = 32*WB_N-1,
  parameter int CL      = WB_N-1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic          m0_we,
  input  logic [CL:0]   m0_cyc,
  output logic [CL:0]   m0_ack,
  output logic [DL:0]   m0_rdata,
  input  logic [15:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic          m1_we,
  input  logic [CL:0]   m1_cyc,
  output logic [CL:0]   m1_ack,
  output logic [DL:0]   m1_rdata,
  output logic [15:0]   wb_addr,
  output logic [31:0]   wb_wdata,
  output logic          wb_we,
  output logic [CL:0]   wb_cyc,
  input  logic [CL:0]   wb_ack,
  input  logic [DL:0]   wb_rdata,
  output logic [1:0]    grant,
  output logic          timeout_err,
  input  logic          err_clr,
  output logic [1:0]    state_dbg
);

  localparam logic [31:0] ABORT_DATA = 32'hFFFF_FFFF;
  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT);

  arb_state_t  state;
  logic        own;
  logic        last;
  logic [15:0] wdog;

  logic        busy;
  logic        abort;
  logic        req0;
  logic        req1;
  logic        winner;
  logic [CL:0] own_cyc;
  logic [CL:0] lane_ack;

  assign state_dbg = state;

  // Arbitration decode; busy is gated by rst so a reset drops the cycle at once.
  always_comb begin
    busy    = (state == ST_BUSY) && !rst;
    own_cyc = own ? m1_cyc : m0_cyc;
    abort   = busy && (wdog == WDOG_LIMIT);
    req0    = |m0_cyc;
    req1    = |m1_cyc;
    winner  = (req0 && req1) ? ~last : req1;
  end

  // Shared-bus side: owner's request while busy, m0 otherwise (don't-care).
  always_comb begin
    wb_addr  = (busy && own) ? m1_addr  : m0_addr;
    wb_wdata = (busy && own) ? m1_wdata : m0_wdata;
    wb_we    = (busy && own) ? m1_we    : m0_we;
    wb_cyc   = (busy && !abort) ? own_cyc : '0;
    grant    = busy ? owner_onehot(own) : 2'b00;
  end

  // Master side: ack routed to the owner only; abort fakes an all-ones read.
  always_comb begin
    m0_ack   = '0;
    m1_ack   = '0;
    m0_rdata = wb_rdata;
    m1_rdata = wb_rdata;
    lane_ack = abort ? own_cyc : wb_ack;
    if (busy) begin
      if (own) m1_ack = lane_ack;
      else     m0_ack = lane_ack;
    end
    if (abort) begin
      for (int l = 0; l < WB_N; l++) begin
        if (own_cyc[l]) begin
          if (own) m1_rdata[32*l +: 32] = ABORT_DATA;
          else     m0_rdata[32*l +: 32] = ABORT_DATA;
        end
      end
    end
  end

  // Arbiter FSM, owner/last registers, watchdog and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      own         <= 1'b0;
      last        <= 1'b1;
      wdog        <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            state <= ST_BUSY;
            own   <= winner;
            wdog  <= 16'd0;
          end
        end
        ST_BUSY: begin
          if (abort || (|wb_ack) || !(|own_cyc)) begin
            state <= ST_HOLD;
            last  <= own;
          end else if (wdog != WDOG_LIMIT) begin
            wdog <= wdog + 16'd1;
          end
        end
        ST_HOLD: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (abort)        timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arb2.sv
// Bench for wb_arb2: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of the arbiter.
module tb_wb_arb2;
  import wb_arb2_pkg::*;

  localparam int WB_N    = 2;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] m0_addr, m1_addr, wb_addr;
  logic [31:0] m0_wdata, m1_wdata, wb_wdata;
  logic        m0_we, m1_we, wb_we;
  logic [1:0]  m0_cyc, m1_cyc, m0_ack, m1_ack, wb_cyc, wb_ack;
  logic [63:0] m0_rdata, m1_rdata, wb_rdata;
  logic [1:0]  grant, state_dbg;
  logic        timeout_err, err_clr;

  wb_arb2 #(.WB_N(WB_N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_cyc(m0_cyc),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_cyc(m1_cyc),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc),
    .wb_ack(wb_ack), .wb_rdata(wb_rdata),
    .grant(grant), .timeout_err(timeout_err), .err_clr(err_clr),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int cyc_no = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc_no, got, exp);
    end
  endtask

  // ---------------- master / slave stimulus state ----------------
  bit          req_on[2];
  logic [1:0]  req_lane[2];
  logic        req_we[2];
  logic [15:0] req_addr[2];
  logic [31:0] req_wdata[2];
  bit          saw_ack[2];
  bit          rand_mode = 0;
  int          slave_lat = 1;
  int          cur_lat = 1;
  int          slave_cnt = 0;

  // ---------------- reference model ----------------
  int          m_owner = -1;  // -1: nobody owns the bus
  bit          m_hold = 0;    // holdoff cycle pending
  int          m_age = 0;     // BUSY cycles elapsed since grant
  int          m_prev = 1;    // previous owner
  bit          m_err = 0;
  logic [1:0]  prev_grant = 2'b00;

  // samples taken at the last negedge
  logic [1:0]  s_grant, s_m0_ack, s_m1_ack, s_wb_cyc, s_state;
  logic [63:0] s_m0_rdata;
  logic        s_err, s_wb_we;
  logic [15:0] s_wb_addr;
  logic [31:0] s_wb_wdata;

  task automatic request(input int i, input logic [1:0] lane, input logic we,
                         input logic [15:0] a, input logic [31:0] d);
    req_on[i] = 1; req_lane[i] = lane; req_we[i] = we;
    req_addr[i] = a; req_wdata[i] = d; saw_ack[i] = 0;
  endtask

  task automatic drive_masters();
    m0_cyc = req_on[0] ? req_lane[0] : 2'b00;
    m0_addr = req_addr[0]; m0_wdata = req_wdata[0]; m0_we = req_we[0];
    m1_cyc = req_on[1] ? req_lane[1] : 2'b00;
    m1_addr = req_addr[1]; m1_wdata = req_wdata[1]; m1_we = req_we[1];
  endtask

  task automatic drive_slave();
    int lat;
    if (wb_cyc != 2'b00) begin
      if (rand_mode && slave_cnt == 0) begin
        lat = $urandom_range(0, 9);
        cur_lat = (lat < 8) ? (lat % 4) : 12;
      end
      lat = rand_mode ? cur_lat : slave_lat;
      wb_ack = (lat >= 0 && slave_cnt >= lat) ? wb_cyc : 2'b00;
    end else begin
      wb_ack = 2'b00;
    end
    wb_rdata = {$urandom(), $urandom()};
  endtask

  task automatic model_check();
    logic [1:0]  mc[2];
    logic [1:0]  e_grant, e_wbcyc, e_state;
    logic [1:0]  e_ack[2];
    logic [63:0] e_rd[2];
    logic [15:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_we;
    logic [1:0]  exp_g;
    bit          abort;
    int          win;
    mc[0] = m0_cyc; mc[1] = m1_cyc;
    e_state = (m_owner >= 0) ? 2'(ST_BUSY) : (m_hold ? 2'(ST_HOLD) : 2'(ST_IDLE));
    e_grant = 2'b00; e_wbcyc = 2'b00; e_ack[0] = 2'b00; e_ack[1] = 2'b00;
    e_rd[0] = wb_rdata; e_rd[1] = wb_rdata;
    e_addr = m0_addr; e_wdata = m0_wdata; e_we = m0_we;
    abort = 0;
    if (!rst && m_owner >= 0) begin
      abort = (m_age == TIMEOUT);
      e_grant = (m_owner == 0) ? 2'b01 : 2'b10;
      e_wbcyc = abort ? 2'b00 : mc[m_owner];
      e_ack[m_owner] = abort ? mc[m_owner] : wb_ack;
      e_addr  = (m_owner == 0) ? m0_addr  : m1_addr;
      e_wdata = (m_owner == 0) ? m0_wdata : m1_wdata;
      e_we    = (m_owner == 0) ? m0_we    : m1_we;
      if (abort)
        for (int l = 0; l < WB_N; l++)
          if (mc[m_owner][l]) e_rd[m_owner][32*l +: 32] = 32'hFFFF_FFFF;
    end

    // grant order: each new grant must match the model's arbitration decision
    if (prev_grant == 2'b00 && grant != 2'b00) begin
      exp_g = 2'b00;
      if (exp_q.size() > 0) exp_g = exp_q.pop_front();
      check("grant_order", 64'(grant), 64'(exp_g));
    end
    prev_grant = grant;

    check("grant", 64'(grant), 64'(e_grant));
    check("wb_cyc", 64'(wb_cyc), 64'(e_wbcyc));
    check("m0_ack", 64'(m0_ack), 64'(e_ack[0]));
    check("m1_ack", 64'(m1_ack), 64'(e_ack[1]));
    check("m0_rdata", m0_rdata, e_rd[0]);
    check("m1_rdata", m1_rdata, e_rd[1]);
    check("wb_addr", 64'(wb_addr), 64'(e_addr));
    check("wb_wdata", 64'(wb_wdata), 64'(e_wdata));
    check("wb_we", 64'(wb_we), 64'(e_we));
    check("timeout_err", 64'(timeout_err), 64'(m_err));
    check("state", 64'(state_dbg), 64'(e_state));

    // advance the model by one clock
    if (rst) begin
      m_owner = -1; m_hold = 0; m_age = 0; m_prev = 1; m_err = 0;
      exp_q.delete();
    end else begin
      if (abort) m_err = 1;
      else if (err_clr) m_err = 0;
      if (m_owner >= 0) begin
        if (abort || wb_ack != 2'b00 || mc[m_owner] == 2'b00) begin
          m_prev = m_owner; m_owner = -1; m_hold = 1;
        end else begin
          m_age++;
        end
      end else if (m_hold) begin
        m_hold = 0;
      end else if (mc[0] != 2'b00 || mc[1] != 2'b00) begin
        if (mc[0] != 2'b00 && mc[1] != 2'b00) win = 1 - m_prev;
        else win = (mc[1] != 2'b00) ? 1 : 0;
        m_owner = win; m_age = 0;
        exp_q.push_back((win == 0) ? 2'b01 : 2'b10);
      end
    end

    s_grant = grant; s_m0_ack = m0_ack; s_m1_ack = m1_ack; s_wb_cyc = wb_cyc;
    s_state = state_dbg; s_m0_rdata = m0_rdata; s_err = timeout_err;
    s_wb_addr = wb_addr; s_wb_wdata = wb_wdata; s_wb_we = wb_we;
    saw_ack[0] = |m0_ack; saw_ack[1] = |m1_ack;
    slave_cnt = (wb_cyc != 2'b00) ? slave_cnt + 1 : 0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      if (saw_ack[i]) begin
        req_on[i] = 0; saw_ack[i] = 0;
      end else if (rand_mode) begin
        if (!req_on[i]) begin
          if ($urandom_range(0, 3) == 0)
            request(i, ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01,
                    1'($urandom_range(0, 1)), 16'($urandom()), $urandom());
        end else if ($urandom_range(0, 49) == 0) begin
          req_on[i] = 0;
        end
      end
    end
    if (rand_mode) err_clr = ($urandom_range(0, 7) == 0);
    drive_masters();
    #1;
    drive_slave();
    @(negedge clk);
    cyc_no++;
    model_check();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    bit found;
    int a0, g1;
    logic [1:0] order[$];
    logic [1:0] pg;

    rst = 1; err_clr = 0; wb_ack = 2'b00; wb_rdata = 64'd0;
    for (int i = 0; i < 2; i++) begin
      req_on[i] = 0; req_lane[i] = 2'b00; req_we[i] = 0;
      req_addr[i] = 16'd0; req_wdata[i] = 32'd0; saw_ack[i] = 0;
    end
    drive_masters();
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) step();
    check("rst_grant", 64'(s_grant), 64'(2'b00));
    check("rst_wb_cyc", 64'(s_wb_cyc), 64'(2'b00));
    check("rst_err", 64'(s_err), 64'(1'b0));
    rst = 0;

    // m0 read of slave 0, slave acks 2 cycles after wb_cyc
    slave_lat = 2;
    request(0, 2'b01, 0, 16'h0010, 32'd0);
    step();
    found = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (s_m0_ack != 2'b00) begin found = 1; break; end
    end
    check("rd_ack_seen", 64'(found), 64'(1));
    check("rd_m0_ack", 64'(s_m0_ack), 64'(2'b01));
    check("rd_m1_ack", 64'(s_m1_ack), 64'(2'b00));
    check("rd_grant", 64'(s_grant), 64'(2'b01));
    step();
    check("rd_hold", 64'(s_state), 64'(2'(ST_HOLD)));
    step();
    check("rd_idle", 64'(s_state), 64'(2'(ST_IDLE)));

    // contention from reset: m0, m1, m0, m1
    rst = 1; step(); rst = 0;
    slave_lat = 1;
    request(0, 2'b01, 0, 16'h0100, 32'h0);
    request(1, 2'b01, 0, 16'h0200, 32'h0);
    pg = 2'b00; a0 = -1; g1 = -1;
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 2; i++)
        if (!req_on[i]) request(i, 2'b01, 0, 16'(16'h0100 * (i + 1)), 32'h0);
      step();
      if (a0 < 0 && s_m0_ack != 2'b00) a0 = cyc_no;
      if (s_grant != 2'b00 && pg == 2'b00) begin
        order.push_back(s_grant);
        if (s_grant == 2'b10 && g1 < 0) g1 = cyc_no;
      end
      pg = s_grant;
    end
    for (int k = 0; k < 4; k++)
      check($sformatf("contend_order%0d", k),
            64'((k < order.size()) ? order[k] : 2'b00),
            64'((k % 2 == 1) ? 2'b10 : 2'b01));
    check("contend_regrant_gap", 64'(g1 - a0), 64'(3));
    req_on[0] = 0; req_on[1] = 0;
    for (int k = 0; k < 4; k++) step();

    // m1 write to slave 1
    slave_lat = 1;
    request(1, 2'b10, 1, 16'h0042, 32'hDEAD_BEEF);
    step();
    step();
    check("wr_addr", 64'(s_wb_addr), 64'(16'h0042));
    check("wr_wdata", 64'(s_wb_wdata), 64'(32'hDEAD_BEEF));
    check("wr_we", 64'(s_wb_we), 64'(1'b1));
    check("wr_cyc", 64'(s_wb_cyc), 64'(2'b10));
    check("wr_grant", 64'(s_grant), 64'(2'b10));
    step();
    check("wr_ack", 64'(s_m1_ack), 64'(2'b10));
    check("wr_m0_ack", 64'(s_m0_ack), 64'(2'b00));
    for (int k = 0; k < 3; k++) step();

    // slave never acks: watchdog abort
    slave_lat = -1;
    request(0, 2'b01, 0, 16'h0300, 32'd0);
    step();
    n = 0; found = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (s_m0_ack != 2'b00) begin found = 1; break; end
      if (s_grant != 2'b00) n++;
    end
    check("to_found", 64'(found), 64'(1));
    check("to_busy_cycles", 64'(n), 64'(TIMEOUT));
    check("to_rdata", s_m0_rdata[31:0], 64'(32'hFFFF_FFFF));
    check("to_wb_cyc", 64'(s_wb_cyc), 64'(2'b00));
    step();
    check("to_err_set", 64'(s_err), 64'(1'b1));
    err_clr = 1;
    step();
    err_clr = 0;
    step();
    check("to_err_clr", 64'(s_err), 64'(1'b0));
    step();
    // err_clr held through a second abort: set wins
    err_clr = 1;
    request(1, 2'b10, 0, 16'h0400, 32'd0);
    step();
    found = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (s_m1_ack != 2'b00) begin found = 1; break; end
    end
    check("to2_found", 64'(found), 64'(1));
    err_clr = 0;
    step();
    check("to2_err_priority", 64'(s_err), 64'(1'b1));
    for (int k = 0; k < 3; k++) step();

    // master drops cyc mid-BUSY
    request(1, 2'b10, 0, 16'h0500, 32'd0);
    step(); step(); step();
    req_on[1] = 0;
    step();
    check("drop_ack", 64'(s_m1_ack), 64'(2'b00));
    check("drop_wb_cyc", 64'(s_wb_cyc), 64'(2'b00));
    step();
    check("drop_hold", 64'(s_state), 64'(2'(ST_HOLD)));
    step();

    // reset while BUSY
    request(0, 2'b01, 0, 16'h0600, 32'd0);
    step(); step();
    check("rstb_pre_grant", 64'(s_grant), 64'(2'b01));
    rst = 1; step(); rst = 0;
    step();
    check("rstb_wb_cyc", 64'(s_wb_cyc), 64'(2'b00));
    check("rstb_grant", 64'(s_grant), 64'(2'b00));
    req_on[0] = 0;
    for (int k = 0; k < 4; k++) step();

    // randomized traffic
    rand_mode = 1;
    for (int k = 0; k < 3000; k++) step();
    rand_mode = 0;
    err_clr = 0;
    req_on[0] = 0; req_on[1] = 0; saw_ack[0] = 0; saw_ack[1] = 0;
    for (int k = 0; k < 10; k++) step();
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
